// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/flush controller: stall bus
// bit positions, FSM state encoding, reset level and the stall encoder helper.
package pipeline_ctrl_pkg;

    localparam int STALL_W  = 6;
    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;
    localparam int STALL_EX = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB = 5;

    localparam logic RST_ENABLE = 1'b1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Stage number of a requester: 0 = none, 1 = IF, 2 = ID, 3 = EX, 4 = MEM.
    typedef logic [2:0] stage_t;

    // Thermometer code: the highest requesting stage k freezes stall[k:0].
    function automatic logic [STALL_W-1:0] stall_mask(input stage_t k);
        logic [STALL_W-1:0] m;
        m = '0;
        for (int i = 0; i < STALL_W; i++) begin
            m[i] = (k != 3'd0) && (i <= int'(k));
        end
        return m;
    endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// Central hazard/flush controller: merges stage stall requests into the
// stall bus, turns a taken EX jump into flush + PC redirect, and defers the
// redirect while an instruction fetch is still outstanding.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              if_busy,
    input  logic              if_done,
    input  logic              jump_in,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [5:0]        stall,
    output logic              flush,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              discard_fetch,
    output logic [CNT_W-1:0]  cnt_stall,
    output logic [CNT_W-1:0]  cnt_flush
);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] tgt_q;
    logic              latch_tgt;
    logic              jump_acc;
    logic              ex_frozen;
    stage_t            top_req;
    stage_t            top_req_squashed;

    // Priority encode the requests: mem > ex > id > if. The squashed variant
    // drops IF/ID requests, whose wrong-path work a jump throws away.
    always_comb begin
        if (stallreq_mem)      top_req = 3'd4;
        else if (stallreq_ex)  top_req = 3'd3;
        else if (stallreq_id)  top_req = 3'd2;
        else if (stallreq_if)  top_req = 3'd1;
        else                   top_req = 3'd0;

        if (stallreq_mem)      top_req_squashed = 3'd4;
        else if (stallreq_ex)  top_req_squashed = 3'd3;
        else                   top_req_squashed = 3'd0;

        // EX is frozen exactly when a stage at or beyond EX is requesting.
        ex_frozen = stallreq_mem || stallreq_ex;
    end

    // Next-state and output decode; outputs are held at zero during reset.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned, which would infer a latch.
        state_d       = state_q;
        stall         = '0;
        flush         = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = tgt_q;
        discard_fetch = 1'b0;
        latch_tgt     = 1'b0;
        jump_acc      = 1'b0;

        if (rst != RST_ENABLE) begin
            case (state_q)
                ST_RUN: begin
                    jump_acc    = jump_in && !ex_frozen;
                    stall       = jump_acc ? stall_mask(top_req_squashed) : stall_mask(top_req);
                    flush       = jump_acc;
                    redirect_pc = jump_target;
                    if (jump_acc) begin
                        if (!if_busy || if_done) begin
                            redirect = 1'b1;
                        end else begin
                            // Fetch still in flight: park the target until it returns.
                            discard_fetch = 1'b1;
                            latch_tgt     = 1'b1;
                            state_d       = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Only bubbles enter ID while the stale fetch drains.
                    stall               = stall_mask(top_req);
                    stall[STALL_PC]     = 1'b1;
                    stall[STALL_IF]     = 1'b1;
                    flush               = 1'b1;
                    discard_fetch       = 1'b1;
                    if (if_done) begin
                        redirect = 1'b1;
                        state_d  = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // State, parked target and free-running performance counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst == RST_ENABLE) begin
            state_q   <= ST_RUN;
            tgt_q     <= '0;
            cnt_stall <= '0;
            cnt_flush <= '0;
        end else begin
            state_q <= state_d;
            if (latch_tgt) begin
                tgt_q <= jump_target;
            end
            cnt_stall <= cnt_stall + {{(CNT_W-1){1'b0}}, stall[STALL_PC]};
            cnt_flush <= cnt_flush + {{(CNT_W-1){1'b0}}, jump_acc};
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a directed vector table for the
// documented scenarios, a counter-wrap sequence, and randomized traffic
// compared against a behavioural model of the controller.
module tb_pipeline_ctrl;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic              if_busy, if_done, jump_in;
    logic [ADDR_W-1:0] jump_target;
    logic [5:0]        stall;
    logic              flush, redirect, discard_fetch;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  cnt_stall, cnt_flush;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .if_busy(if_busy), .if_done(if_done),
        .jump_in(jump_in), .jump_target(jump_target),
        .stall(stall), .flush(flush), .redirect(redirect),
        .redirect_pc(redirect_pc), .discard_fetch(discard_fetch),
        .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
    );

    typedef struct {
        logic        rst;
        logic        req_if, req_id, req_ex, req_mem;
        logic        busy, done, jump;
        logic [31:0] target;
        logic [5:0]  e_stall;
        logic        e_flush, e_redir;
        logic [31:0] e_pc;
        logic        e_disc;
    } vec_t;

    // Behavioural model state: are we waiting out a stale fetch, and where to go after.
    bit          m_valid = 1'b0;
    bit          m_drain = 1'b0;
    logic [31:0] m_tgt   = '0;
    logic [7:0]  m_cs    = '0;
    logic [7:0]  m_cf    = '0;

    // Model outputs for the current cycle.
    logic [5:0]  x_stall;
    logic        x_flush, x_redir, x_disc, x_jacc;
    logic [31:0] x_pc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] reqs, input logic b, input logic d,
                                input logic j, input logic [31:0] t, input logic [5:0] es,
                                input logic ef, input logic er, input logic [31:0] ep, input logic ed);
        vec_t v;
        v.rst = r;
        {v.req_mem, v.req_ex, v.req_id, v.req_if} = reqs;
        v.busy = b; v.done = d; v.jump = j; v.target = t;
        v.e_stall = es; v.e_flush = ef; v.e_redir = er; v.e_pc = ep; v.e_disc = ed;
        return v;
    endfunction

    // Evaluate the controller rules for the inputs currently applied.
    task automatic model_eval();
        int k;
        k = stallreq_mem ? 4 : stallreq_ex ? 3 : stallreq_id ? 2 : stallreq_if ? 1 : 0;
        x_jacc  = !m_drain && jump_in && (k < 3);
        if (x_jacc) k = 0;
        x_stall = (k == 0) ? 6'd0 : 6'((1 << (k + 1)) - 1);
        if (m_drain) x_stall = x_stall | 6'b000011;
        x_flush = m_drain || x_jacc;
        x_redir = m_drain ? if_done : (x_jacc && (!if_busy || if_done));
        x_pc    = m_drain ? m_tgt : jump_target;
        x_disc  = m_drain || (x_jacc && if_busy && !if_done);
        if (rst) begin
            x_stall = '0; x_flush = 0; x_redir = 0; x_disc = 0; x_jacc = 0;
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_valid = 1; m_drain = 0; m_tgt = '0; m_cs = '0; m_cf = '0;
        end else begin
            m_cs = m_cs + 8'(x_stall[0]);
            m_cf = m_cf + 8'(x_jacc);
            if (m_drain) begin
                if (if_done) m_drain = 0;
            end else if (x_jacc && if_busy && !if_done) begin
                m_drain = 1;
                m_tgt   = jump_target;
            end
        end
    endtask

    // Drive one cycle; compare against the vector (use_table) or the model.
    task automatic apply(input vec_t v, input bit use_table, input string tag);
        rst = v.rst;
        stallreq_if = v.req_if; stallreq_id = v.req_id;
        stallreq_ex = v.req_ex; stallreq_mem = v.req_mem;
        if_busy = v.busy; if_done = v.done; jump_in = v.jump; jump_target = v.target;
        @(negedge clk);
        model_eval();
        if (use_table) begin
            check({tag, " stall"}, 64'(stall), 64'(v.e_stall));
            check({tag, " flush"}, 64'(flush), 64'(v.e_flush));
            check({tag, " redirect"}, 64'(redirect), 64'(v.e_redir));
            check({tag, " discard"}, 64'(discard_fetch), 64'(v.e_disc));
            if (v.e_redir) check({tag, " redirect_pc"}, 64'(redirect_pc), 64'(v.e_pc));
        end else begin
            check({tag, " stall"}, 64'(stall), 64'(x_stall));
            check({tag, " flush"}, 64'(flush), 64'(x_flush));
            check({tag, " redirect"}, 64'(redirect), 64'(x_redir));
            check({tag, " discard"}, 64'(discard_fetch), 64'(x_disc));
            if (x_redir) check({tag, " redirect_pc"}, 64'(redirect_pc), 64'(x_pc));
        end
        if (m_valid) begin
            check({tag, " cnt_stall"}, 64'(cnt_stall), 64'(m_cs));
            check({tag, " cnt_flush"}, 64'(cnt_flush), 64'(m_cf));
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    vec_t tbl[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst = 1; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        if_busy = 0; if_done = 0; jump_in = 0; jump_target = '0;

        //            rst  {mem,ex,id,if} busy done jump target   stall      flush redir pc     disc
        tbl[0]  = mk(1, 4'b0000, 0, 0, 0, 32'h0,   6'b000000, 0, 0, 32'h0,   0);
        tbl[1]  = mk(0, 4'b0010, 0, 0, 0, 32'h0,   6'b000111, 0, 0, 32'h0,   0);
        tbl[2]  = mk(0, 4'b1000, 0, 0, 0, 32'h0,   6'b011111, 0, 0, 32'h0,   0);
        tbl[3]  = mk(0, 4'b1000, 0, 0, 1, 32'h80,  6'b011111, 0, 0, 32'h0,   0);
        tbl[4]  = mk(0, 4'b0010, 0, 0, 1, 32'h100, 6'b000000, 1, 1, 32'h100, 0);
        tbl[5]  = mk(0, 4'b0000, 1, 0, 1, 32'h200, 6'b000000, 1, 0, 32'h0,   1);
        tbl[6]  = mk(0, 4'b0000, 1, 0, 0, 32'h0,   6'b000011, 1, 0, 32'h0,   1);
        tbl[7]  = mk(0, 4'b0000, 1, 0, 0, 32'h0,   6'b000011, 1, 0, 32'h0,   1);
        tbl[8]  = mk(0, 4'b0000, 1, 1, 0, 32'h0,   6'b000011, 1, 1, 32'h200, 1);
        tbl[9]  = mk(0, 4'b0000, 0, 0, 0, 32'h0,   6'b000000, 0, 0, 32'h0,   0);
        tbl[10] = mk(0, 4'b0000, 1, 0, 1, 32'h300, 6'b000000, 1, 0, 32'h0,   1);
        tbl[11] = mk(0, 4'b0000, 1, 0, 0, 32'h0,   6'b000011, 1, 0, 32'h0,   1);
        tbl[12] = mk(1, 4'b0000, 1, 0, 0, 32'h0,   6'b000000, 0, 0, 32'h0,   0);
        tbl[13] = mk(0, 4'b0000, 0, 0, 0, 32'h0,   6'b000000, 0, 0, 32'h0,   0);

        @(posedge clk); #1;
        foreach (tbl[i]) apply(tbl[i], 1'b1, $sformatf("vec%0d", i));
        check("post-reset cnt_flush", 64'(cnt_flush), 64'(0));
        check("post-reset cnt_stall", 64'(cnt_stall), 64'(0));

        // Counter wrap: hold an IF stall for 2^CNT_W cycles after reset.
        v = mk(1, 4'b0000, 0, 0, 0, 32'h0, 6'b0, 0, 0, 32'h0, 0);
        apply(v, 1'b0, "wrap-rst");
        v.rst = 0; v.req_if = 1;
        for (int i = 0; i < 255; i++) apply(v, 1'b0, "wrap");
        check("wrap cnt_stall max", 64'(cnt_stall), 64'(255));
        apply(v, 1'b0, "wrap");
        check("wrap cnt_stall zero", 64'(cnt_stall), 64'(0));

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            v.rst     = ($urandom_range(0, 63) == 0);
            v.req_if  = ($urandom_range(0, 3) == 0);
            v.req_id  = ($urandom_range(0, 3) == 0);
            v.req_ex  = ($urandom_range(0, 5) == 0);
            v.req_mem = ($urandom_range(0, 5) == 0);
            v.busy    = $urandom_range(0, 1);
            v.done    = ($urandom_range(0, 2) == 0);
            v.jump    = ($urandom_range(0, 2) == 0);
            v.target  = $urandom;
            apply(v, 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
